// File: rtl/uart_tx_ctrl.sv
// UART transmit frame sequencer: pops the TX FIFO, frames each character (start/data/parity/stop) and times bits with a baud counter.
// Latency: pop in cycle t, start bit driven on uart_tx_o from t+1; each bit lasts max(div_i,2) cycles.
// Backpressure: pops only when tx_empty_i is low, at most once per frame; an empty FIFO leaves the line idle high.
module uart_tx_ctrl #(
    parameter int DIV_WIDTH = 16
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic [DIV_WIDTH-1:0] div_i,
    input  logic [1:0]           wls_i,
    input  logic                 pen_i,
    input  logic [1:0]           ps_i,
    input  logic                 stb_i,
    input  logic                 tx_empty_i,
    input  logic [7:0]           tx_data_i,
    output logic                 tx_pop_o,
    output logic                 uart_tx_o,
    output logic                 busy_o,
    output logic                 temt_o,
    output logic                 done_o
);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_PARITY,
        ST_STOP
    } state_t;

    state_t               state, state_n;
    logic [DIV_WIDTH-1:0] baud_cnt, baud_cnt_n;
    logic [2:0]           bit_idx, bit_idx_n;
    logic                 stop_cnt, stop_cnt_n;
    logic [7:0]           data_q;
    logic [1:0]           wls_q;
    logic                 pen_q;
    logic [1:0]           ps_q;
    logic                 stb_q;
    logic [DIV_WIDTH-1:0] div_q;
    logic                 line_q, line_n;

    logic                 load;
    logic                 pop;
    logic                 done;
    logic [DIV_WIDTH-1:0] div_eff;
    logic                 bit_end;
    logic                 last_data;
    logic [7:0]           data_mask;
    logic                 data_xor;
    logic                 parity_bit;

    // A divider below 2 would make the start bit collapse into the pop cycle, so clamp it.
    assign div_eff   = (div_i < DIV_WIDTH'(2)) ? DIV_WIDTH'(2) : div_i;
    assign bit_end   = (baud_cnt == (div_q - DIV_WIDTH'(1)));
    assign last_data = (bit_idx == ({1'b0, wls_q} + 3'd4));

    // Parity covers only the N configured data bits of the latched character.
    always_comb begin
        data_mask = 8'hFF;
        case (wls_q)
            2'b00:   data_mask = 8'h1F;
            2'b01:   data_mask = 8'h3F;
            2'b10:   data_mask = 8'h7F;
            default: data_mask = 8'hFF;
        endcase
        data_xor = ^(data_q & data_mask);
        case (ps_q)
            2'b00:   parity_bit = data_xor;
            2'b01:   parity_bit = ~data_xor;
            2'b10:   parity_bit = 1'b1;
            default: parity_bit = 1'b0;
        endcase
    end

    // Next-state, bit counters, pop/done strobes and the next line level.
    always_comb begin
        state_n    = state;
        baud_cnt_n = baud_cnt + DIV_WIDTH'(1);
        bit_idx_n  = bit_idx;
        stop_cnt_n = stop_cnt;
        load       = 1'b0;
        pop        = 1'b0;
        done       = 1'b0;
        line_n     = 1'b1;

        case (state)
            ST_IDLE: begin
                baud_cnt_n = '0;
                if (!tx_empty_i) begin
                    pop     = 1'b1;
                    load    = 1'b1;
                    state_n = ST_START;
                end
            end
            ST_START: begin
                if (bit_end) begin
                    baud_cnt_n = '0;
                    bit_idx_n  = 3'd0;
                    state_n    = ST_DATA;
                end
            end
            ST_DATA: begin
                if (bit_end) begin
                    baud_cnt_n = '0;
                    if (last_data) begin
                        bit_idx_n  = 3'd0;
                        stop_cnt_n = 1'b0;
                        state_n    = pen_q ? ST_PARITY : ST_STOP;
                    end else begin
                        bit_idx_n = bit_idx + 3'd1;
                    end
                end
            end
            ST_PARITY: begin
                if (bit_end) begin
                    baud_cnt_n = '0;
                    stop_cnt_n = 1'b0;
                    state_n    = ST_STOP;
                end
            end
            ST_STOP: begin
                if (bit_end) begin
                    baud_cnt_n = '0;
                    if (stop_cnt == stb_q) begin
                        done       = 1'b1;
                        stop_cnt_n = 1'b0;
                        if (!tx_empty_i) begin
                            pop     = 1'b1;
                            load    = 1'b1;
                            state_n = ST_START;
                        end else begin
                            state_n = ST_IDLE;
                        end
                    end else begin
                        stop_cnt_n = 1'b1;
                    end
                end
            end
            default: begin
                baud_cnt_n = '0;
                state_n    = ST_IDLE;
            end
        endcase

        // The line register follows the state being entered, so the bit appears with its state.
        case (state_n)
            ST_START:  line_n = 1'b0;
            ST_DATA:   line_n = data_q[bit_idx_n];
            ST_PARITY: line_n = parity_bit;
            default:   line_n = 1'b1;
        endcase
    end

    // State, counters, line register and the per-frame configuration snapshot.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state    <= ST_IDLE;
            baud_cnt <= '0;
            bit_idx  <= 3'd0;
            stop_cnt <= 1'b0;
            data_q   <= 8'h00;
            wls_q    <= 2'b00;
            pen_q    <= 1'b0;
            ps_q     <= 2'b00;
            stb_q    <= 1'b0;
            div_q    <= '0;
            line_q   <= 1'b1;
        end else begin
            state    <= state_n;
            baud_cnt <= baud_cnt_n;
            bit_idx  <= bit_idx_n;
            stop_cnt <= stop_cnt_n;
            line_q   <= line_n;
            if (load) begin
                data_q <= tx_data_i;
                wls_q  <= wls_i;
                pen_q  <= pen_i;
                ps_q   <= ps_i;
                stb_q  <= stb_i;
                div_q  <= div_eff;
            end
        end
    end

    // Strobes are suppressed while reset is asserted so no character is lost from the FIFO.
    assign tx_pop_o  = pop & ~rst_i;
    assign done_o    = done & ~rst_i;
    assign uart_tx_o = line_q;
    assign busy_o    = (state != ST_IDLE);
    assign temt_o    = tx_empty_i & ~busy_o;

endmodule

// File: tb/tb_uart_tx_ctrl.sv
module tb_uart_tx_ctrl;

    logic        clk = 1'b0;
    logic        rst_i;
    logic [15:0] div_i;
    logic [1:0]  wls_i;
    logic        pen_i;
    logic [1:0]  ps_i;
    logic        stb_i;
    logic        tx_empty_i;
    logic [7:0]  tx_data_i;
    logic        tx_pop_o;
    logic        uart_tx_o;
    logic        busy_o;
    logic        temt_o;
    logic        done_o;

    uart_tx_ctrl #(.DIV_WIDTH(16)) dut (
        .clk_i      (clk),
        .rst_i      (rst_i),
        .div_i      (div_i),
        .wls_i      (wls_i),
        .pen_i      (pen_i),
        .ps_i       (ps_i),
        .stb_i      (stb_i),
        .tx_empty_i (tx_empty_i),
        .tx_data_i  (tx_data_i),
        .tx_pop_o   (tx_pop_o),
        .uart_tx_o  (uart_tx_o),
        .busy_o     (busy_o),
        .temt_o     (temt_o),
        .done_o     (done_o)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [15:0] div;
        logic [1:0]  wls;
        logic        pen;
        logic [1:0]  ps;
        logic        stb;
        logic [7:0]  data;
        int          exp_d;
        int          exp_nbits;
        logic [11:0] exp_bits;   // bit i = i-th bit on the line, start bit first
    } vec_t;

    vec_t       vecs[8];
    logic [7:0] fifo[$];
    logic       exp_line[$];
    logic       pop_pend;
    int         n_pop  = 0;
    int         n_chk  = 0;
    int         n_fail = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic drive();
        tx_empty_i = (fifo.size() == 0);
        tx_data_i  = (fifo.size() == 0) ? 8'h00 : fifo[0];
    endtask

    task automatic push(input logic [7:0] b);
        fifo.push_back(b);
        drive();
    endtask

    // Observe the pop just before the edge, then retire the popped entry just after it.
    task automatic step();
        logic [7:0] dummy;
        #3;
        pop_pend = tx_pop_o;
        if (tx_pop_o) n_pop++;
        @(posedge clk);
        #1;
        if (pop_pend && fifo.size() > 0) dummy = fifo.pop_front();
        drive();
        #1;
    endtask

    task automatic add_frame(input logic [11:0] bits, input int nbits, input int d);
        for (int i = 0; i < nbits; i++)
            for (int j = 0; j < d; j++)
                exp_line.push_back(bits[i]);
    endtask

    // Runs from the pop cycle through the expected line sequence, then checks the idle return.
    task automatic run_check(input string name, input int npop_exp, input int ndone_exp,
                             input int chg_at, input logic [15:0] chg_div);
        int pop0;
        int done_c;
        int busy_c;
        int len;
        pop0   = n_pop;
        done_c = 0;
        busy_c = 0;
        len    = exp_line.size();
        for (int c = 0; c < len; c++) begin
            step();
            chk($sformatf("%s line c%0d", name, c), 32'(uart_tx_o), 32'(exp_line[c]));
            if (done_o) done_c++;
            if (busy_o) busy_c++;
            if (c == len - 1) chk({name, " done_last"}, 32'(done_o), 32'd1);
            if (c == chg_at) div_i = chg_div;
        end
        step();
        chk({name, " idle_line"}, 32'(uart_tx_o), 32'd1);
        chk({name, " idle_busy"}, 32'(busy_o), 32'd0);
        chk({name, " idle_temt"}, 32'(temt_o), 32'd1);
        chk({name, " pops"}, 32'(n_pop - pop0), 32'(npop_exp));
        chk({name, " dones"}, 32'(done_c), 32'(ndone_exp));
        chk({name, " busy_cycles"}, 32'(busy_c), 32'(len));
        exp_line.delete();
    endtask

    initial begin
        int pop_before;
        int bad_line;
        int bad_temt;

        vecs[0] = '{16'd4, 2'b11, 1'b0, 2'b00, 1'b0, 8'h55, 4, 10, 12'h2AA};  // 8N1
        vecs[1] = '{16'd3, 2'b00, 1'b1, 2'b00, 1'b1, 8'hF3, 3,  9, 12'h1E6};  // 5E2
        vecs[2] = '{16'd3, 2'b00, 1'b1, 2'b01, 1'b1, 8'hF3, 3,  9, 12'h1A6};  // 5O2
        vecs[3] = '{16'd3, 2'b00, 1'b1, 2'b10, 1'b1, 8'hF3, 3,  9, 12'h1E6};  // 5M2
        vecs[4] = '{16'd3, 2'b00, 1'b1, 2'b11, 1'b1, 8'hF3, 3,  9, 12'h1A6};  // 5S2
        vecs[5] = '{16'd0, 2'b11, 1'b0, 2'b00, 1'b0, 8'h0F, 2, 10, 12'h21E};  // div 0 clamps to 2
        vecs[6] = '{16'd2, 2'b10, 1'b1, 2'b01, 1'b0, 8'h80, 2, 10, 12'h300};  // 7O1, bit 7 ignored
        vecs[7] = '{16'd1, 2'b01, 1'b0, 2'b00, 1'b1, 8'hED, 2,  9, 12'h1DA};  // 6N2, div 1 clamps

        rst_i = 1'b1;
        div_i = 16'd4;
        wls_i = 2'b11;
        pen_i = 1'b0;
        ps_i  = 2'b00;
        stb_i = 1'b0;
        drive();
        repeat (3) step();

        // Reset state
        chk("rst line", 32'(uart_tx_o), 32'd1);
        chk("rst busy", 32'(busy_o), 32'd0);
        chk("rst pop", 32'(tx_pop_o), 32'd0);
        chk("rst done", 32'(done_o), 32'd0);
        chk("rst temt", 32'(temt_o), 32'd1);
        rst_i = 1'b0;
        step();

        // Empty FIFO: nothing moves for 100 cycles
        pop_before = n_pop;
        bad_line   = 0;
        bad_temt   = 0;
        for (int i = 0; i < 100; i++) begin
            step();
            if (uart_tx_o !== 1'b1) bad_line++;
            if (temt_o !== 1'b1) bad_temt++;
        end
        chk("empty pops", 32'(n_pop - pop_before), 32'd0);
        chk("empty line_low_cycles", 32'(bad_line), 32'd0);
        chk("empty temt_low_cycles", 32'(bad_temt), 32'd0);

        // Table of single frames
        for (int i = 0; i < 8; i++) begin
            div_i = vecs[i].div;
            wls_i = vecs[i].wls;
            pen_i = vecs[i].pen;
            ps_i  = vecs[i].ps;
            stb_i = vecs[i].stb;
            push(vecs[i].data);
            add_frame(vecs[i].exp_bits, vecs[i].exp_nbits, vecs[i].exp_d);
            run_check($sformatf("vec%0d", i), 1, 1, -1, 16'd0);
            step();
        end

        // Back-to-back 8N1 at div 2: no idle gap, busy for 40 cycles
        div_i = 16'd2;
        wls_i = 2'b11;
        pen_i = 1'b0;
        stb_i = 1'b0;
        push(8'hA5);
        push(8'h3C);
        add_frame({2'b00, 1'b1, 8'hA5, 1'b0}, 10, 2);
        add_frame({2'b00, 1'b1, 8'h3C, 1'b0}, 10, 2);
        run_check("b2b", 2, 2, -1, 16'd0);
        step();

        // Divider change mid-frame: first frame keeps 4, second uses 8
        div_i = 16'd4;
        push(8'h55);
        push(8'h96);
        add_frame({2'b00, 1'b1, 8'h55, 1'b0}, 10, 4);
        add_frame({2'b00, 1'b1, 8'h96, 1'b0}, 10, 8);
        run_check("divlatch", 2, 2, 10, 16'd8);
        step();

        // Reset during DATA bit 3, then a clean frame from the still-pending byte
        div_i = 16'd4;
        push(8'h55);
        for (int c = 0; c < 17; c++) step();
        chk("mid busy", 32'(busy_o), 32'd1);
        chk("mid line_bit3", 32'(uart_tx_o), 32'd0);
        push(8'h3C);
        rst_i = 1'b1;
        #1;
        chk("mid rst pop", 32'(tx_pop_o), 32'd0);
        pop_before = n_pop;
        step();
        chk("after rst line", 32'(uart_tx_o), 32'd1);
        chk("after rst busy", 32'(busy_o), 32'd0);
        chk("after rst pops", 32'(n_pop - pop_before), 32'd0);
        rst_i = 1'b0;
        #1;
        add_frame({2'b00, 1'b1, 8'h3C, 1'b0}, 10, 4);
        run_check("post_rst", 1, 1, -1, 16'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
